hamming_frame_decoder: RTL and testbench

Receive-side counterpart of the Hamming frame encoder: consumes the serial 64-bit line frames that encoder emits, acquires frame sync on the 8-bit header, and decodes the eight Hamming(7,4) codewords. Delivers one corrected 32-bit word per frame with error status. Sits directly downstream of the encoder's `data_out` on the link, in a single clock domain running at the line bit rate.

---
 rtl/hamming_frame_decoder_if.sv | 23 ++
 rtl/hamming_frame_decoder.sv | 180 ++++++++++++++++++
 tb/tb_hamming_frame_decoder.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/hamming_frame_decoder_if.sv
// Serial line link into the Hamming frame decoder and its decoded result bus.
// master = line side (drives bits, observes results), slave = decoder side.
`timescale 1ns/1ps
interface hamming_frame_decoder_if;
    logic        bit_in;
    logic        bit_valid;
    logic [31:0] data_out;
    logic        data_out_valid;
    logic        first_frame;
    logic [3:0]  err_corrected;
    logic        locked;
    logic        sync_lost;

    modport master (
        output bit_in, bit_valid,
        input  data_out, data_out_valid, first_frame, err_corrected, locked, sync_lost
    );

    modport slave (
        input  bit_in, bit_valid,
        output data_out, data_out_valid, first_frame, err_corrected, locked, sync_lost
    );
endinterface

// File: rtl/hamming_frame_decoder.sv
// Hamming frame decoder: hunts for the 8-bit frame header on the serial line,
// shifts in 56 payload bits (eight Hamming(7,4) codewords) and delivers one
// 32-bit word per frame with a count of codewords whose syndrome was nonzero.
// The word is decoded from the payload as the 56th bit is accepted, so
// data_out_valid is high during the single DECODE cycle that follows.
// Optional feature macro: HAMMING_DEC_CORRECT_EN -- when defined, single-bit
// errors are corrected before data extraction; otherwise detection only.
`timescale 1ns/1ps
module hamming_frame_decoder #(
    parameter int unsigned SYNC_CONFIRM = 1   // good headers needed for lock, 1..7
) (
    input  logic                    clk_in,
    input  logic                    rst,
    hamming_frame_decoder_if.slave  bus
);

    localparam logic [7:0] HDR_NORMAL = 8'h7E;
    localparam logic [7:0] HDR_FIRST  = 8'h6E;

    typedef enum logic [1:0] {HUNT, PAYLOAD, DECODE, CHECK} state_t;

    typedef struct packed {
        logic [3:0] data;
        logic       err;
    } cw_dec_t;

    state_t      state;
    logic [7:0]  hdr_sr;
    logic [55:0] payload;
    logic [5:0]  bit_cnt;
    logic [2:0]  good_cnt;
    logic        marker;

    logic [31:0] data_out_q;
    logic        data_valid_q;
    logic        first_q;
    logic [3:0]  err_q;
    logic        locked_q;
    logic        sync_lost_q;

    logic [7:0]  hdr_next;
    logic        hdr_ok;
    logic [55:0] payload_next;
    cw_dec_t     dec [8];
    logic [31:0] dec_data;
    logic [3:0]  dec_errs;

    // Decode one codeword: bit k is Hamming position k+1, data on 3,5,6,7.
    function automatic cw_dec_t decode_cw(input logic [6:0] cw);
        logic [2:0] syn;
        cw_dec_t    r;
`ifdef HAMMING_DEC_CORRECT_EN
        logic [6:0] fixed;
`endif
        syn[0] = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
        syn[1] = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
        syn[2] = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
`ifdef HAMMING_DEC_CORRECT_EN
        fixed = cw;
        for (int k = 0; k < 7; k++) begin
            if (syn == 3'(k + 1)) fixed[k] = ~cw[k];
        end
        r.data = {fixed[6], fixed[5], fixed[4], fixed[2]};
`else
        r.data = {cw[6], cw[5], cw[4], cw[2]};
`endif
        r.err = |syn;
        return r;
    endfunction

    assign hdr_next     = {hdr_sr[6:0], bus.bit_in};
    assign hdr_ok       = (hdr_next == HDR_NORMAL) || (hdr_next == HDR_FIRST);
    assign payload_next = {payload[54:0], bus.bit_in};

    for (genvar g = 0; g < 8; g++) begin : g_cw
        assign dec[g] = decode_cw(payload_next[7*g +: 7]);
    end

    // Gather the eight decoded nibbles and the nonzero-syndrome count (max 8).
    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch.
        dec_data = '0;
        dec_errs = '0;
        for (int i = 0; i < 8; i++) begin
            dec_data[4*i +: 4] = dec[i].data;
            dec_errs           = dec_errs + {3'b000, dec[i].err};
        end
    end

    // Frame sync FSM, payload shifting and registered result outputs.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state        <= HUNT;
            hdr_sr       <= '0;
            // NOTE: payload is a plain shift register, not a memory, so it is
            // cleared with the rest of the state.
            payload      <= '0;
            bit_cnt      <= '0;
            good_cnt     <= '0;
            marker       <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            first_q      <= 1'b0;
            err_q        <= '0;
            locked_q     <= 1'b0;
            sync_lost_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every branch sees start-of-cycle state.
            data_valid_q <= 1'b0;
            sync_lost_q  <= 1'b0;
            case (state)
                HUNT: begin
                    if (bus.bit_valid) begin
                        hdr_sr <= hdr_next;
                        if (hdr_ok) begin
                            state    <= PAYLOAD;
                            bit_cnt  <= '0;
                            marker   <= (hdr_next == HDR_FIRST);
                            good_cnt <= 3'd1;
                            locked_q <= (SYNC_CONFIRM <= 32'd1);
                        end
                    end
                end
                PAYLOAD: begin
                    if (bus.bit_valid) begin
                        payload <= payload_next;
                        if (bit_cnt == 6'd55) begin
                            state        <= DECODE;
                            bit_cnt      <= '0;
                            data_out_q   <= dec_data;
                            err_q        <= dec_errs;
                            first_q      <= marker;
                            data_valid_q <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end
                end
                DECODE: begin
                    // A bit accepted here is the first bit of the next header.
                    state <= CHECK;
                    if (bus.bit_valid) begin
                        hdr_sr  <= hdr_next;
                        bit_cnt <= 6'd1;
                    end
                end
                CHECK: begin
                    if (bus.bit_valid) begin
                        hdr_sr <= hdr_next;
                        if (bit_cnt == 6'd7) begin
                            bit_cnt <= '0;
                            if (hdr_ok) begin
                                state  <= PAYLOAD;
                                marker <= (hdr_next == HDR_FIRST);
                                if (good_cnt != 3'd7) good_cnt <= good_cnt + 3'd1;
                                if ({29'd0, good_cnt} + 32'd1 >= SYNC_CONFIRM) locked_q <= 1'b1;
                            end else begin
                                state       <= HUNT;
                                good_cnt    <= '0;
                                locked_q    <= 1'b0;
                                sync_lost_q <= locked_q;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

    assign bus.data_out       = data_out_q;
    assign bus.data_out_valid = data_valid_q;
    assign bus.first_frame    = first_q;
    assign bus.err_corrected  = err_q;
    assign bus.locked         = locked_q;
    assign bus.sync_lost      = sync_lost_q;

endmodule

// File: tb/tb_hamming_frame_decoder.sv
// Bench for hamming_frame_decoder: frames are driven serially, the expected
// result of each delivered frame is queued when it is sent and compared when
// data_out_valid pulses.
`timescale 1ns/1ps
module tb_hamming_frame_decoder;

    typedef struct {
        logic [31:0] data;
        logic        first;
        logic [3:0]  err;
    } exp_t;

`ifdef HAMMING_DEC_CORRECT_EN
    localparam logic [31:0] EXP_FLIP = 32'h0000_0000;
    localparam logic [31:0] EXP_PAT  = 32'hF38D_6EEF;
`else
    localparam logic [31:0] EXP_FLIP = 32'h0000_0800;
    localparam logic [31:0] EXP_PAT  = 32'h739D_EEFF;
`endif

    logic clk_in = 1'b0;
    logic rst    = 1'b1;

    hamming_frame_decoder_if bus ();

    hamming_frame_decoder #(.SYNC_CONFIRM(1)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    exp_t sb_q [$];
    exp_t mon_e;
    int   n_checks      = 0;
    int   n_pass        = 0;
    int   sync_lost_cnt = 0;
    int   valid_cnt     = 0;
    time  last_payload_t = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Output monitor: compare each delivered word against the scoreboard.
    always @(negedge clk_in) begin
        if (bus.data_out_valid === 1'b1) begin
            valid_cnt++;
            check("valid_latency_ns", 32'($time - last_payload_t), 32'd10);
            if (sb_q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("data_out", bus.data_out, mon_e.data);
                check("first_frame", {31'd0, bus.first_frame}, {31'd0, mon_e.first});
                check("err_corrected", {28'd0, bus.err_corrected}, {28'd0, mon_e.err});
            end
        end
        if (bus.sync_lost === 1'b1) begin
            sync_lost_cnt++;
            check("sync_lost_alone", {31'd0, bus.data_out_valid}, 32'd0);
        end
    end

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_bit(input logic b, input bit gaps);
        int n = 0;
        while (gaps && n < 4 && $urandom_range(1, 0) == 1) begin
            @(negedge clk_in);
            bus.bit_valid = 1'b0;
            n++;
        end
        @(negedge clk_in);
        bus.bit_in    = b;
        bus.bit_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_in);
            bus.bit_valid = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] hdr, input logic [55:0] pl, input bit gaps,
                              input bit expect_out, input logic [31:0] exp_data,
                              input logic exp_first, input logic [3:0] exp_err);
        exp_t e;
        if (expect_out) begin
            e.data  = exp_data;
            e.first = exp_first;
            e.err   = exp_err;
            sb_q.push_back(e);
        end
        for (int i = 7; i >= 0; i--) drive_bit(hdr[i], gaps);
        for (int i = 55; i >= 0; i--) begin
            drive_bit(pl[i], gaps);
            if (i == 0) last_payload_t = $time;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},      bus.data_out, 32'd0);
        check({tag, "_valid"},     {31'd0, bus.data_out_valid}, 32'd0);
        check({tag, "_first"},     {31'd0, bus.first_frame}, 32'd0);
        check({tag, "_err"},       {28'd0, bus.err_corrected}, 32'd0);
        check({tag, "_locked"},    {31'd0, bus.locked}, 32'd0);
        check({tag, "_sync_lost"}, {31'd0, bus.sync_lost}, 32'd0);
    endtask

    initial begin
        logic [55:0] ones;
        logic [55:0] zeros;
        logic [55:0] flip20;
        logic [55:0] pat;
        ones   = {56{1'b1}};
        zeros  = '0;
        flip20 = 56'h00_0000_0010_0000;
        pat    = 56'h7E_7E7E_7E7E_7E7E;

        bus.bit_in    = 1'b0;
        bus.bit_valid = 1'b0;
        rst           = 1'b1;
        repeat (3) @(negedge clk_in);
        rst = 1'b0;
        check_reset_outputs("reset");

        // Acquisition from HUNT; lock immediately with one confirming header.
        send_frame(8'h7E, ones, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 4'd0);
        check("locked_after_acquire", {31'd0, bus.locked}, 32'd1);

        // First-frame marker, then a single flipped bit in codeword 2 position 7.
        send_frame(8'h6E, zeros, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 4'd0);
        send_frame(8'h7E, flip20, 1'b0, 1'b1, EXP_FLIP, 1'b0, 4'd1);

        // Every codeword carries an error: count saturates at 8; gapless then gapped.
        send_frame(8'h7E, pat, 1'b0, 1'b1, EXP_PAT, 1'b0, 4'd8);
        send_frame(8'h7E, pat, 1'b1, 1'b1, EXP_PAT, 1'b0, 4'd8);
        check("locked_before_bad_header", {31'd0, bus.locked}, 32'd1);

        // Corrupt header while locked: sync lost, frame not delivered.
        send_frame(8'h7F, zeros, 1'b0, 1'b0, 32'd0, 1'b0, 4'd0);
        check("locked_after_bad_header", {31'd0, bus.locked}, 32'd0);
        check("sync_lost_pulses", 32'(sync_lost_cnt), 32'd1);

        // Re-acquire.
        send_frame(8'h7E, ones, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 4'd0);
        check("locked_after_reacquire", {31'd0, bus.locked}, 32'd1);

        // Reset in the middle of a payload: partial frame discarded.
        for (int i = 7; i >= 0; i--) drive_bit(8'h7E >> i, 1'b0);
        for (int i = 0; i < 30; i++) drive_bit(1'b1, 1'b0);
        @(negedge clk_in);
        bus.bit_valid = 1'b0;
        rst           = 1'b1;
        @(negedge clk_in);
        rst = 1'b0;
        check_reset_outputs("mid_reset");
        send_frame(8'h7E, ones, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 4'd0);

        idle(12);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        check("valid_pulses", 32'(valid_cnt), 32'd7);
        check("sync_lost_total", 32'(sync_lost_cnt), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
